// File: rtl/sound_latch_rx.sv
// rtl/sound_latch_rx.sv - main-to-sound CPU command latch FIFO with interrupt handshake
module sound_latch_rx #(
    parameter int DEPTH    = 4,
    parameter int ACK_MODE = 1
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic                     mcpu_wr_en,
    input  logic [7:0]               mcpu_data,
    input  logic                     scpu_rd_en,
    input  logic                     scpu_iack,
    input  logic                     scpu_flush,
    output logic [7:0]               latch_dout,
    output logic                     scpu_int_n,
    output logic                     pending,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_SERVICE
    } irq_state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    last_q;
    logic          overrun_q;
    logic          int_lvl_q;
    irq_state_t    state;
    irq_state_t    state_nxt;

    logic empty;
    logic full;
    logic pop;
    logic push;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = scpu_rd_en && !empty;
    // A full FIFO still takes a write when the same edge frees a slot.
    assign push  = mcpu_wr_en && (!full || pop);

    always_ff @(posedge clk_sys) begin
        if (rst_n && push && !scpu_flush) begin
            mem[wr_ptr] <= mcpu_data;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_q    <= '0;
            overrun_q <= 1'b0;
        end else if (scpu_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (mcpu_wr_en && full && !pop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (scpu_flush || (ACK_MODE == 0)) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (!empty)   state_nxt = S_ASSERT;
                S_ASSERT:  if (scpu_iack) state_nxt = S_SERVICE;
                S_SERVICE: if (pop)       state_nxt = S_IDLE;
                default:                  state_nxt = S_IDLE;
            endcase
        end
    end

    // Level-mode interrupt simply mirrors emptiness one edge late.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            int_lvl_q <= 1'b1;
        end else if (scpu_flush) begin
            int_lvl_q <= 1'b1;
        end else begin
            int_lvl_q <= empty;
        end
    end

    assign scpu_int_n = (ACK_MODE != 0) ? (state != S_ASSERT) : int_lvl_q;
    assign latch_dout = empty ? last_q : mem[rd_ptr];
    assign pending    = !empty;
    assign overrun    = overrun_q;
    assign level      = count;

endmodule

// File: tb/tb_sound_latch_rx.sv
// tb/tb_sound_latch_rx.sv - self-checking bench for sound_latch_rx with queue-based model
module tb_sound_latch_rx;

    localparam int DEPTH = 4;

    logic       clk_sys = 1'b0;
    logic       rst_n = 1'b0;
    logic       mcpu_wr_en = 1'b0;
    logic [7:0] mcpu_data = 8'h00;
    logic       scpu_rd_en = 1'b0;
    logic       scpu_iack = 1'b0;
    logic       scpu_flush = 1'b0;
    logic [7:0] latch_dout;
    logic       scpu_int_n;
    logic       pending;
    logic       overrun;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    sound_latch_rx #(.DEPTH(DEPTH), .ACK_MODE(1)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .mcpu_wr_en (mcpu_wr_en),
        .mcpu_data  (mcpu_data),
        .scpu_rd_en (scpu_rd_en),
        .scpu_iack  (scpu_iack),
        .scpu_flush (scpu_flush),
        .latch_dout (latch_dout),
        .scpu_int_n (scpu_int_n),
        .pending    (pending),
        .overrun    (overrun),
        .level      (level)
    );

    always #5 clk_sys = ~clk_sys;

    // Model: queue of bytes, last popped byte, sticky drop flag, and where the
    // sound CPU is in its interrupt handshake.
    localparam int M_QUIET   = 0;
    localparam int M_RAISED  = 1;
    localparam int M_HANDLED = 2;

    logic [7:0] mq[$];
    logic [7:0] m_last = 8'h00;
    bit         m_ovr = 1'b0;
    int         m_irq = M_QUIET;
    int         m_n;
    bit         m_pop;

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_last = 8'h00;
            m_ovr  = 1'b0;
            m_irq  = M_QUIET;
        end else if (scpu_flush) begin
            mq.delete();
            m_ovr = 1'b0;
            m_irq = M_QUIET;
        end else begin
            m_n   = mq.size();
            m_pop = scpu_rd_en && (m_n > 0);
            if (m_irq == M_QUIET && m_n > 0)          m_irq = M_RAISED;
            else if (m_irq == M_RAISED && scpu_iack)  m_irq = M_HANDLED;
            else if (m_irq == M_HANDLED && m_pop)     m_irq = M_QUIET;
            if (m_pop) m_last = mq.pop_front();
            if (mcpu_wr_en) begin
                if (m_n < DEPTH || m_pop) mq.push_back(mcpu_data);
                else m_ovr = 1'b1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        check("cyc_level",   int'(level),      mq.size());
        check("cyc_pending", int'(pending),    int'(mq.size() > 0));
        check("cyc_overrun", int'(overrun),    int'(m_ovr));
        check("cyc_int_n",   int'(scpu_int_n), int'(m_irq != M_RAISED));
        check("cyc_dout",    int'(latch_dout), (mq.size() > 0) ? int'(mq[0]) : int'(m_last));
    end

    task automatic step(input bit wr, input logic [7:0] d, input bit rd, input bit ia, input bit fl);
        mcpu_wr_en = wr;
        mcpu_data  = d;
        scpu_rd_en = rd;
        scpu_iack  = ia;
        scpu_flush = fl;
        @(posedge clk_sys);
        #1;
        mcpu_wr_en = 1'b0;
        scpu_rd_en = 1'b0;
        scpu_iack  = 1'b0;
        scpu_flush = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic iack();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic flush();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] exp_seq [4];

        idle();
        idle();
        check("rst_level", int'(level), 0);
        check("rst_int_n", int'(scpu_int_n), 1);
        check("rst_dout", int'(latch_dout), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        // Single byte with acknowledge
        wr(8'h5A);
        check("t1_level_after_wr", int'(level), 1);
        check("t1_int_n_edge1", int'(scpu_int_n), 1);
        check("t1_dout_head", int'(latch_dout), 8'h5A);
        idle();
        check("t1_int_n_edge2", int'(scpu_int_n), 0);
        iack();
        check("t1_int_n_after_iack", int'(scpu_int_n), 1);
        rd();
        check("t1_dout_last", int'(latch_dout), 8'h5A);
        check("t1_level_end", int'(level), 0);
        idle();
        check("t1_int_n_quiet", int'(scpu_int_n), 1);

        // Overrun on 5th write
        for (int i = 1; i <= 5; i++) wr(8'(i));
        check("t2_level_full", int'(level), 4);
        check("t2_overrun", int'(overrun), 1);
        for (int i = 1; i <= 4; i++) begin
            check("t2_pop_value", int'(latch_dout), i);
            rd();
        end
        check("t2_level_empty", int'(level), 0);
        check("t2_dout_last", int'(latch_dout), 8'h04);
        flush();
        check("t2_flush_overrun", int'(overrun), 0);
        check("t2_flush_keeps_last", int'(latch_dout), 8'h04);

        // Full FIFO with simultaneous write and pop
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        check("t3_level_stays", int'(level), 4);
        check("t3_overrun_stays", int'(overrun), 0);
        exp_seq[0] = 8'h22; exp_seq[1] = 8'h33; exp_seq[2] = 8'h44; exp_seq[3] = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            check("t3_pop_value", int'(latch_dout), int'(exp_seq[i]));
            rd();
        end
        check("t3_fourth_pop_last", int'(latch_dout), 8'hAA);
        flush();

        // Two interrupt pulses for two bytes
        wr(8'h10);
        check("t4_int_n_w1", int'(scpu_int_n), 1);
        wr(8'h20);
        check("t4_int_n_pulse1", int'(scpu_int_n), 0);
        iack();
        check("t4_int_n_service1", int'(scpu_int_n), 1);
        rd();
        check("t4_int_n_idle", int'(scpu_int_n), 1);
        check("t4_dout_second", int'(latch_dout), 8'h20);
        idle();
        check("t4_int_n_pulse2", int'(scpu_int_n), 0);
        iack();
        check("t4_int_n_service2", int'(scpu_int_n), 1);
        rd();
        idle();
        check("t4_int_n_done", int'(scpu_int_n), 1);
        check("t4_level_done", int'(level), 0);

        // Empty FIFO, simultaneous write and read
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        check("t5_level_one", int'(level), 1);
        check("t5_dout", int'(latch_dout), 8'h33);
        rd();
        rd();
        check("t5_empty_read_level", int'(level), 0);
        check("t5_empty_read_dout", int'(latch_dout), 8'h33);
        check("t5_empty_read_ovr", int'(overrun), 0);
        flush();

        // Flush versus reset with data queued and interrupt asserted
        wr(8'h71); wr(8'h72); wr(8'h73);
        check("t6_level_three", int'(level), 3);
        check("t6_int_low", int'(scpu_int_n), 0);
        flush();
        check("t6_flush_level", int'(level), 0);
        check("t6_flush_int_n", int'(scpu_int_n), 1);
        check("t6_flush_dout", int'(latch_dout), 8'h33);
        wr(8'h81); wr(8'h82); wr(8'h83);
        idle();
        check("t6_refill_int_low", int'(scpu_int_n), 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_level", int'(level), 0);
        check("t6_rst_int_n", int'(scpu_int_n), 1);
        check("t6_rst_dout", int'(latch_dout), 0);
        check("t6_rst_pending", int'(pending), 0);
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        wr(8'h99);
        check("t6_post_rst_level", int'(level), 1);
        check("t6_post_rst_dout", int'(latch_dout), 8'h99);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
